// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal_sync dispatch path: mask width, event kind
// and the per-port event record (the barrier id is carried alongside it).
package fractal_sync_pkg;

  localparam int unsigned SD_WIDTH = 2;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_RSP  = 2'd1,
    EVT_UP   = 2'd2
  } evt_kind_e;

  typedef struct packed {
    evt_kind_e             kind;
    logic [SD_WIDTH-1:0]   mask;
    logic                  err;
  } evt_t;

endpackage

// File: rtl/fractal_sync_evt_fifo.sv
// Valid/ready event FIFO with registered storage; a push becomes visible on
// the cycle after it is written (no fall-through).
module fractal_sync_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_ok, pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop     = valid_o & ready_i;
  // Gate the read port so the output bus is zero whenever nothing is queued.
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fractal_sync_1d_evt_dispatch.sv
// Dispatch stage after the 1D local RF: classifies RF verdicts into response
// or forward events, buffers one per port and round-robins them into two FIFOs.
module fractal_sync_1d_evt_dispatch
  import fractal_sync_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = 3,
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned RSP_FIFO_DEPTH = 4,
  parameter int unsigned UP_FIFO_DEPTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_PORTS-1:0]  check_i,
  input  logic [ID_WIDTH-1:0] id_i      [N_PORTS],
  input  logic [SD_WIDTH-1:0] sd_i      [N_PORTS],
  input  logic [N_PORTS-1:0]  present_i,
  input  logic [SD_WIDTH-1:0] rf_sd_i   [N_PORTS],
  input  logic [N_PORTS-1:0]  id_err_i,
  input  logic [N_PORTS-1:0]  bypass_i,
  input  logic [N_PORTS-1:0]  ignore_i,
  output logic [N_PORTS-1:0]  stall_o,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [ID_WIDTH-1:0] rsp_id_o,
  output logic [SD_WIDTH-1:0] rsp_dst_o,
  output logic                rsp_err_o,
  output logic                up_valid_o,
  input  logic                up_ready_i,
  output logic [ID_WIDTH-1:0] up_id_o,
  output logic [SD_WIDTH-1:0] up_sd_o
);

  localparam int unsigned PTR_W   = $clog2(N_PORTS);
  localparam int unsigned RSP_W   = ID_WIDTH + SD_WIDTH + 1;
  localparam int unsigned UP_W    = ID_WIDTH + SD_WIDTH;

  evt_t                new_evt  [N_PORTS];
  logic [SD_WIDTH-1:0] comb_sd  [N_PORTS];
  logic [N_PORTS-1:0]  hit;

  evt_t                evt_q    [N_PORTS];
  evt_t                evt_d    [N_PORTS];
  logic [ID_WIDTH-1:0] eid_q    [N_PORTS];
  logic [ID_WIDTH-1:0] eid_d    [N_PORTS];

  logic [N_PORTS-1:0]  rsp_req, up_req;
  logic [PTR_W-1:0]    rsp_ptr_q, rsp_ptr_d, up_ptr_q, up_ptr_d;
  logic [PTR_W:0]      rsp_pick, up_pick;
  logic [PTR_W-1:0]    rsp_idx, up_idx;
  logic                rsp_gnt, up_gnt;
  logic                rsp_full, up_full;
  logic [RSP_W-1:0]    rsp_wdata, rsp_rdata;
  logic [UP_W-1:0]     up_wdata, up_rdata;

  // First requester at or after ptr, scanning cyclically; MSB flags a hit.
  function automatic logic [PTR_W:0] rr_pick(input logic [PTR_W-1:0] ptr,
                                             input logic [N_PORTS-1:0] req);
    logic [PTR_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned k = N_PORTS; k > 0; k--) begin
      idx = (int'(ptr) + k - 1) % N_PORTS;
      if (req[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(N_PORTS - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  // Classification: ignore > id error > present > bypass, else stored in RF.
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      new_evt[i] = '{kind: EVT_NONE, mask: '0, err: 1'b0};
      comb_sd[i] = '0;
      hit[i]     = 1'b0;
      if (check_i[i] && !ignore_i[i]) begin
        if (id_err_i[i]) begin
          new_evt[i] = '{kind: EVT_RSP, mask: sd_i[i], err: 1'b1};
        end else if (present_i[i]) begin
          comb_sd[i] = sd_i[i] | rf_sd_i[i];
          hit[i]     = 1'b1;
        end else if (bypass_i[i]) begin
          comb_sd[i] = sd_i[i];
          // Descending scan so the lowest matching partner is the one kept.
          for (int unsigned j = N_PORTS - 1; j > i; j--) begin
            if (check_i[j] && ignore_i[j] &&
                (id_i[j][ID_WIDTH-1:1] == id_i[i][ID_WIDTH-1:1]))
              comb_sd[i] = sd_i[i] | sd_i[j];
          end
          hit[i] = 1'b1;
        end
        if (hit[i])
          new_evt[i] = '{kind: (id_i[i][0] ? EVT_RSP : EVT_UP),
                         mask: comb_sd[i], err: 1'b0};
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      rsp_req[i] = (evt_q[i].kind == EVT_RSP);
      up_req[i]  = (evt_q[i].kind == EVT_UP);
      stall_o[i] = (evt_q[i].kind != EVT_NONE);
    end
  end

  assign rsp_pick = rr_pick(rsp_ptr_q, rsp_req);
  assign up_pick  = rr_pick(up_ptr_q, up_req);
  assign rsp_idx  = rsp_pick[PTR_W-1:0];
  assign up_idx   = up_pick[PTR_W-1:0];
  assign rsp_gnt  = rsp_pick[PTR_W] & ~rsp_full;
  assign up_gnt   = up_pick[PTR_W] & ~up_full;

  always_comb begin
    rsp_ptr_d = rsp_ptr_q;
    up_ptr_d  = up_ptr_q;
    if (rsp_gnt) rsp_ptr_d = ptr_next(rsp_idx);
    if (up_gnt)  up_ptr_d  = ptr_next(up_idx);
    rsp_wdata = {eid_q[rsp_idx], evt_q[rsp_idx].mask, evt_q[rsp_idx].err};
    up_wdata  = {eid_q[up_idx], evt_q[up_idx].mask};
  end

  // A granted register empties this edge; reload waits for the next check.
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      evt_d[i] = evt_q[i];
      eid_d[i] = eid_q[i];
      if ((rsp_gnt && rsp_idx == PTR_W'(i)) || (up_gnt && up_idx == PTR_W'(i))) begin
        evt_d[i].kind = EVT_NONE;
      end else if (evt_q[i].kind == EVT_NONE && new_evt[i].kind != EVT_NONE) begin
        evt_d[i] = new_evt[i];
        eid_d[i] = id_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_ptr_q <= '0;
      up_ptr_q  <= '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        evt_q[i] <= '{kind: EVT_NONE, mask: '0, err: 1'b0};
        eid_q[i] <= '0;
      end
    end else begin
      rsp_ptr_q <= rsp_ptr_d;
      up_ptr_q  <= up_ptr_d;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        evt_q[i] <= evt_d[i];
        eid_q[i] <= eid_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(|(check_i & stall_o)));
  end

  fractal_sync_evt_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH (RSP_W)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_gnt),
    .data_i  (rsp_wdata),
    .full_o  (rsp_full),
    .valid_o (rsp_valid_o),
    .ready_i (rsp_ready_i),
    .data_o  (rsp_rdata)
  );

  fractal_sync_evt_fifo #(
    .DEPTH (UP_FIFO_DEPTH),
    .WIDTH (UP_W)
  ) i_up_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (up_gnt),
    .data_i  (up_wdata),
    .full_o  (up_full),
    .valid_o (up_valid_o),
    .ready_i (up_ready_i),
    .data_o  (up_rdata)
  );

  assign {rsp_id_o, rsp_dst_o, rsp_err_o} = rsp_rdata;
  assign {up_id_o, up_sd_o}               = up_rdata;

endmodule

// File: tb/tb_fractal_sync_1d_evt_dispatch.sv
// Directed bench for the 1D event dispatch stage with a scoreboard per channel.
module tb_fractal_sync_1d_evt_dispatch;
  import fractal_sync_pkg::*;

  localparam int unsigned IW = 3;
  localparam int unsigned NP = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0]       check, present, id_err, bypass, ignore, stall;
  logic [IW-1:0]       id    [NP];
  logic [SD_WIDTH-1:0] sd    [NP];
  logic [SD_WIDTH-1:0] rf_sd [NP];
  logic                rsp_valid, rsp_ready, rsp_err, up_valid, up_ready;
  logic [IW-1:0]       rsp_id, up_id;
  logic [SD_WIDTH-1:0] rsp_dst, up_sd;

  always #5 clk = ~clk;

  fractal_sync_1d_evt_dispatch #(
    .ID_WIDTH       (IW),
    .N_PORTS        (NP),
    .RSP_FIFO_DEPTH (2),
    .UP_FIFO_DEPTH  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .check_i     (check),
    .id_i        (id),
    .sd_i        (sd),
    .present_i   (present),
    .rf_sd_i     (rf_sd),
    .id_err_i    (id_err),
    .bypass_i    (bypass),
    .ignore_i    (ignore),
    .stall_o     (stall),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_dst_o   (rsp_dst),
    .rsp_err_o   (rsp_err),
    .up_valid_o  (up_valid),
    .up_ready_i  (up_ready),
    .up_id_o     (up_id),
    .up_sd_o     (up_sd)
  );

  typedef struct packed {
    logic [IW-1:0]       id;
    logic [SD_WIDTH-1:0] m;
    logic                err;
  } exp_t;

  exp_t rsp_q[$];
  exp_t up_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_q.size()), 32'd1);
        else chk("rsp_beat", 32'({rsp_id, rsp_dst, rsp_err}), 32'(rsp_q.pop_front()));
      end
      if (up_valid && up_ready) begin
        if (up_q.size() == 0) chk("up_unexpected", 32'(up_q.size()), 32'd1);
        else chk("up_beat", 32'({up_id, up_sd, 1'b0}), 32'(up_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    check = '0; present = '0; id_err = '0; bypass = '0; ignore = '0;
    for (int i = 0; i < NP; i++) begin
      id[i] = '0; sd[i] = '0; rf_sd[i] = '0;
    end
  endtask

  task automatic set_port(input int p, input logic [IW-1:0] pid, input logic [SD_WIDTH-1:0] psd,
                          input logic [SD_WIDTH-1:0] prf, input logic pres, input logic perr,
                          input logic pbyp, input logic pign);
    check[p] = 1'b1; id[p] = pid; sd[p] = psd; rf_sd[p] = prf;
    present[p] = pres; id_err[p] = perr; bypass[p] = pbyp; ignore[p] = pign;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_dst, rsp_err}), 32'd0);
    chk({tag, "_up"}, 32'({up_valid, up_id, up_sd}), 32'd0);
  endtask

  task automatic wait_stall_low(input int p);
    for (int n = 0; n < 20 && stall[p]; n++) cyc();
    chk("stall_release", 32'(stall[p]), 32'd0);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && (rsp_q.size() != 0 || up_q.size() != 0); n++) cyc();
    chk("drain_rsp", 32'(rsp_q.size()), 32'd0);
    chk("drain_up", 32'(up_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    // Reset with every input asserted.
    rst_n = 1'b0; rsp_ready = 1'b1; up_ready = 1'b1;
    check = '1; present = '1; id_err = '1; bypass = '1; ignore = '1;
    for (int i = 0; i < NP; i++) begin
      id[i] = '1; sd[i] = '1; rf_sd[i] = '1;
    end
    #2;
    for (int n = 0; n < 3; n++) begin
      chk_outputs_zero("reset");
      cyc();
    end
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Present, terminal: response after two cycles.
    set_port(0, 3'b101, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    rsp_q.push_back(exp_t'{3'd5, 2'b11, 1'b0});
    cyc(); idle();
    chk("present_stall_c1", 32'(stall), 32'b01);
    chk("present_valid_c1", 32'(rsp_valid), 32'd0);
    cyc();
    chk("present_valid_c2", 32'({rsp_valid, rsp_id, rsp_dst, rsp_err}), 32'({1'b1, 3'd5, 2'b11, 1'b0}));
    chk("present_stall_c2", 32'(stall), 32'd0);
    wait_drain();

    // Bypass with ignore partner: one forward, no response.
    set_port(0, 3'b010, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    set_port(1, 3'b010, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    up_q.push_back(exp_t'{3'd2, 2'b11, 1'b0});
    cyc(); idle();
    chk("bypass_stall", 32'(stall), 32'b01);
    cyc();
    chk("bypass_up", 32'({up_valid, up_id, up_sd}), 32'({1'b1, 3'd2, 2'b11}));
    chk("bypass_no_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    chk("bypass_single", 32'(up_valid), 32'd0);
    wait_drain();

    // Id error on port 1 echoes id with the request mask.
    set_port(1, 3'b110, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    rsp_q.push_back(exp_t'{3'd6, 2'b10, 1'b1});
    cyc(); idle(); cyc();
    chk("iderr_rsp", 32'({rsp_valid, rsp_id, rsp_dst, rsp_err}), 32'({1'b1, 3'd6, 2'b10, 1'b1}));
    wait_drain();

    // Backpressure: depth-2 FIFO fills, third event held in the register.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_stall_low(0);
      set_port(0, {2'(k + 1), 1'b1}, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      rsp_q.push_back(exp_t'{{2'(k + 1), 1'b1}, 2'b01, 1'b0});
      cyc(); idle();
    end
    cyc(); cyc(); cyc();
    chk("full_stall", 32'(stall), 32'b01);
    chk("full_head", 32'({rsp_valid, rsp_id}), 32'({1'b1, 3'd3}));
    rsp_ready = 1'b1;
    wait_drain();
    cyc();
    chk("full_stall_drop", 32'(stall), 32'd0);

    // Contention: fresh pointers, port0 then port1.
    do_reset();
    set_port(0, 3'b001, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    set_port(1, 3'b011, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    rsp_q.push_back(exp_t'{3'd1, 2'b01, 1'b0});
    rsp_q.push_back(exp_t'{3'd3, 2'b10, 1'b0});
    cyc(); idle(); cyc();
    chk("cont1_first", 32'({rsp_valid, rsp_id}), 32'({1'b1, 3'd1}));
    wait_drain();

    // A lone port0 grant moves the pointer to port1.
    set_port(0, 3'b101, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    rsp_q.push_back(exp_t'{3'd5, 2'b01, 1'b0});
    cyc(); idle();
    wait_drain();

    set_port(0, 3'b111, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    set_port(1, 3'b011, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    rsp_q.push_back(exp_t'{3'd3, 2'b10, 1'b0});
    rsp_q.push_back(exp_t'{3'd7, 2'b01, 1'b0});
    cyc(); idle(); cyc();
    chk("cont2_first", 32'({rsp_valid, rsp_id}), 32'({1'b1, 3'd3}));
    wait_drain();

    // Reset while responses are queued: nothing survives.
    rsp_ready = 1'b0;
    wait_stall_low(0);
    set_port(0, 3'b001, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    set_port(1, 3'b011, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); idle(); cyc(); cyc(); cyc();
    chk("middrain_pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    cyc();
    chk_outputs_zero("rst_next");
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cyc();
      chk("no_stale", 32'({rsp_valid, stall}), 32'd0);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
